// File: rtl/colorshield_driver.sv
// colorshield_driver: serial driver for the DM163-based 8x8 RGB shield.
// Loads the 6-bit gamma bank once, then scans rows 0..7 from an external frame buffer.
module colorshield_driver #(
    parameter int CLK_DIV     = 4,
    parameter int HOLD_CYCLES = 1024,
    parameter int RST_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [5:0]  pixel_addr,
    input  logic [23:0] pixel_data,
    output logic        sck,
    output logic        sda,
    output logic        lat,
    output logic        sb,
    output logic        shield_rst_n,
    output logic [7:0]  channel,
    output logic        shield_ready,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        S_SHIELD_RST  = 3'd0,
        S_GAMMA       = 3'd1,
        S_GAMMA_LATCH = 3'd2,
        S_FETCH       = 3'd3,
        S_SHIFT       = 3'd4,
        S_ROW_LATCH   = 3'd5,
        S_ROW_ON      = 3'd6
    } state_t;

    localparam int BIT_CYCLES = 2 * CLK_DIV;
    localparam int CNT_MAX0   = (HOLD_CYCLES > RST_CYCLES) ? HOLD_CYCLES : RST_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX0 > BIT_CYCLES) ? CNT_MAX0 : BIT_CYCLES;
    localparam int CW         = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] LAT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] HALF      = CW'(CLK_DIV);
    localparam logic [7:0]    GAMMA_LAST = 8'd143;
    localparam logic [7:0]    PIX_LAST   = 8'd23;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    bit_q, bit_d;
    logic [2:0]    col_q, col_d;
    logic [2:0]    row_q, row_d;
    logic [23:0]   sr_q, sr_d;
    logic          ready_d;

    logic [5:0]    pixel_addr_q, pixel_addr_d;
    logic          sck_q, sck_d;
    logic          sda_q, sda_d;
    logic          lat_q, lat_d;
    logic          sb_q, sb_d;
    logic          shield_rst_n_q, shield_rst_n_d;
    logic [7:0]    channel_q, channel_d;
    logic          shield_ready_q;

    // Next-state: one shared counter times reset, bit phases, latches and row hold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        col_d   = col_q;
        row_d   = row_q;
        sr_d    = sr_q;
        ready_d = 1'b0;
        case (state_q)
            S_SHIELD_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_GAMMA;
                    cnt_d   = '0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAMMA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == GAMMA_LAST) begin
                        state_d = S_GAMMA_LATCH;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAMMA_LATCH: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    col_d   = 3'd7;
                    row_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_FETCH: begin
                if (cnt_q == '0) begin
                    cnt_d = 1'b1;
                end else begin
                    // Reorder so the bit stream leaves as B, G, R, each MSB first.
                    sr_d    = {pixel_data[7:0], pixel_data[15:8], pixel_data[23:16]};
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_SHIFT: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (bit_q == PIX_LAST) begin
                        if (col_q == 3'd0) begin
                            state_d = S_ROW_LATCH;
                        end else begin
                            col_d   = col_q - 1'b1;
                            state_d = S_FETCH;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                        sr_d  = {sr_q[22:0], 1'b0};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ROW_LATCH: begin
                if (cnt_q == LAT_LAST) begin
                    state_d = S_ROW_ON;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ROW_ON: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    col_d   = 3'd7;
                    if (row_q == 3'd7) begin
                        row_d   = 3'd0;
                        ready_d = 1'b1;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_SHIELD_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with state_q.
    always_comb begin
        sck_d          = ((state_d == S_GAMMA) || (state_d == S_SHIFT)) && (cnt_d >= HALF);
        sda_d          = sda_q;
        if (state_d == S_GAMMA) begin
            sda_d = 1'b1;
        end else if (state_d == S_SHIFT) begin
            sda_d = sr_d[23];
        end
        lat_d          = (state_d == S_GAMMA_LATCH) || (state_d == S_ROW_LATCH);
        sb_d           = sb_q | (state_d == S_FETCH);
        shield_rst_n_d = (state_d != S_SHIELD_RST);
        channel_d      = (state_d == S_ROW_ON) ? (8'b1 << row_d) : 8'b0;
        pixel_addr_d   = (state_d == S_FETCH) ? {row_d, col_d} : pixel_addr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_SHIELD_RST;
            cnt_q          <= '0;
            bit_q          <= '0;
            col_q          <= 3'd7;
            row_q          <= 3'd0;
            sr_q           <= '0;
            pixel_addr_q   <= '0;
            sck_q          <= 1'b0;
            sda_q          <= 1'b0;
            lat_q          <= 1'b0;
            sb_q           <= 1'b0;
            shield_rst_n_q <= 1'b0;
            channel_q      <= '0;
            shield_ready_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            col_q          <= col_d;
            row_q          <= row_d;
            sr_q           <= sr_d;
            pixel_addr_q   <= pixel_addr_d;
            sck_q          <= sck_d;
            sda_q          <= sda_d;
            lat_q          <= lat_d;
            sb_q           <= sb_d;
            shield_rst_n_q <= shield_rst_n_d;
            channel_q      <= channel_d;
            shield_ready_q <= ready_d;
        end
    end

    assign pixel_addr   = pixel_addr_q;
    assign sck          = sck_q;
    assign sda          = sda_q;
    assign lat          = lat_q;
    assign sb           = sb_q;
    assign shield_rst_n = shield_rst_n_q;
    assign channel      = channel_q;
    assign shield_ready = shield_ready_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_colorshield_driver.sv
// Directed bench for colorshield_driver: gamma load, row shift order, scan/wrap,
// read latency, mid-shift reset, and a CLK_DIV=1 instance checked in parallel.
module tb_colorshield_driver;
    localparam int HOLD = 8;
    localparam logic [191:0] ROW0_BITS = {24'h0100FF, 168'h0};
    localparam logic [191:0] ROW1_BITS = {24'hBEADDE, 168'h0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: CLK_DIV=2
    logic [5:0]  addr_a;
    logic [23:0] pd_a = '0;
    logic        sck_a, sda_a, lat_a, sb_a, srst_a, rdy_a;
    logic [7:0]  ch_a;
    logic [2:0]  st_a;
    // DUT B: CLK_DIV=1
    logic [5:0]  addr_b;
    logic [23:0] pd_b = '0;
    logic        sck_b, sda_b, lat_b, sb_b, srst_b, rdy_b;
    logic [7:0]  ch_b;
    logic [2:0]  st_b;

    colorshield_driver #(.CLK_DIV(2), .HOLD_CYCLES(HOLD), .RST_CYCLES(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .pixel_addr(addr_a), .pixel_data(pd_a),
        .sck(sck_a), .sda(sda_a), .lat(lat_a), .sb(sb_a), .shield_rst_n(srst_a),
        .channel(ch_a), .shield_ready(rdy_a), .dbg_state(st_a)
    );

    colorshield_driver #(.CLK_DIV(1), .HOLD_CYCLES(HOLD), .RST_CYCLES(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pixel_addr(addr_b), .pixel_data(pd_b),
        .sck(sck_b), .sda(sda_b), .lat(lat_b), .sb(sb_b), .shield_rst_n(srst_b),
        .channel(ch_b), .shield_ready(rdy_b), .dbg_state(st_b)
    );

    // Frame buffer: data appears only in the single cycle after a new address.
    logic [23:0] mem [64];
    logic [5:0]  prev_a = '0;
    logic [5:0]  prev_b = '0;
    always @(posedge clk) begin
        prev_a <= addr_a;
        prev_b <= addr_b;
        pd_a   <= (addr_a != prev_a) ? mem[addr_a] : 24'h0;
        pd_b   <= (addr_b != prev_b) ? mem[addr_b] : 24'h0;
    end

    int ready_pulses = 0;
    always @(negedge clk) if (rdy_a) ready_pulses++;

    // Recorder for the first row shifted by the CLK_DIV=1 instance.
    logic         b_prev = 1'b0;
    logic         b_done = 1'b0;
    int           b_rises = 0, b_gap2 = 0, b_gap4 = 0, b_run = 0, b_max_run = 0;
    int           b_last = 0, b_cyc = 0;
    logic [191:0] b_bits = '0;
    always @(negedge clk) begin
        b_cyc++;
        if (rst_n && sb_b && !b_done) begin
            if (lat_b) begin
                b_done = 1'b1;
            end else begin
                if (sck_b) b_run++; else b_run = 0;
                if (b_run > b_max_run) b_max_run = b_run;
                if (sck_b && !b_prev) begin
                    if (b_rises > 0) begin
                        if (b_cyc - b_last == 2) b_gap2++;
                        else if (b_cyc - b_last == 4) b_gap4++;
                    end
                    b_rises++;
                    b_last = b_cyc;
                    b_bits = {b_bits[190:0], sda_b};
                end
            end
        end
        b_prev = sck_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Samples on negedges until lat rises, recording every sck rising edge.
    task automatic collect_shift(output int rises, output int ones, output int sb_hi,
                                 output int ch_nz, output logic [191:0] bits, output logic tmo);
        logic prev;
        int   n;
        rises = 0; ones = 0; sb_hi = 0; ch_nz = 0; bits = '0; tmo = 1'b0;
        prev = sck_a;
        n = 0;
        while (!lat_a && !tmo) begin
            if (n == 5000) begin
                tmo = 1'b1;
            end else begin
                @(negedge clk);
                n++;
                if (sck_a && !prev) begin
                    rises++;
                    bits = {bits[190:0], sda_a};
                    if (sda_a) ones++;
                    if (sb_a) sb_hi++;
                end
                if (ch_a != 8'h0) ch_nz++;
                prev = sck_a;
            end
        end
    endtask

    task automatic count_lat(output int n, output int bad);
        n = 0; bad = 0;
        while (lat_a && n < 100) begin
            if (sck_a) bad++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_hold(input logic [7:0] exp, output int n);
        n = 0;
        while (ch_a == exp && n < 2000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_rst_low(output int n);
        n = 1;
        while (n < 200) begin
            @(negedge clk);
            if (srst_a == 1'b0) n++;
            else break;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int           rises, ones, sb_hi, ch_nz, n, bad;
        logic [191:0] bits;
        logic         tmo;

        for (int i = 0; i < 64; i++) mem[i] = 24'h0;
        mem[6'o07] = 24'hFF0001;
        mem[6'o17] = 24'hDEADBE;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", {addr_a, sck_a, sda_a, lat_a, sb_a, srst_a, ch_a, rdy_a}, 20'h0);
        chk("reset_outputs_b", {addr_b, sck_b, sda_b, lat_b, sb_b, srst_b, ch_b, rdy_b}, 20'h0);
        chk("reset_state", st_a, 3'd0);

        // Shield reset pulse then gamma load
        rst_n = 1'b1;
        count_rst_low(n);
        chk("shield_rst_low_cycles", n, 16);
        collect_shift(rises, ones, sb_hi, ch_nz, bits, tmo);
        chk("gamma_timeout", tmo, 1'b0);
        chk("gamma_rises", rises, 144);
        chk("gamma_sda_ones", ones, 144);
        chk("gamma_sb_high", sb_hi, 0);
        count_lat(n, bad);
        chk("gamma_lat_len", n, 2);
        chk("gamma_lat_sck", bad, 0);
        chk("sb_after_gamma", {sb_a, lat_a}, 2'b10);

        // Row 0: single coloured pixel at column 7
        collect_shift(rises, ones, sb_hi, ch_nz, bits, tmo);
        chk("row0_rises", rises, 192);
        chk("row0_bits", bits, ROW0_BITS);
        chk("row0_blank", ch_nz, 0);
        count_lat(n, bad);
        chk("row0_lat_len", n, 2);
        count_hold(8'h01, n);
        chk("row0_hold", n, HOLD);
        chk("row0_after_hold", {ch_a, rdy_a}, 9'h0);

        // Row 1: read-latency pattern
        collect_shift(rises, ones, sb_hi, ch_nz, bits, tmo);
        chk("row1_bits", bits, ROW1_BITS);
        count_lat(n, bad);
        count_hold(8'h02, n);
        chk("row1_hold", n, HOLD);

        // Rows 2..7 and frame end
        for (int r = 2; r < 8; r++) begin
            collect_shift(rises, ones, sb_hi, ch_nz, bits, tmo);
            if (r == 7) chk("no_early_ready", ready_pulses, 0);
            count_lat(n, bad);
            count_hold(8'(1 << r), n);
            chk($sformatf("row%0d_hold", r), n, HOLD);
        end
        chk("ready_pulse", {rdy_a, ch_a}, {1'b1, 8'h00});
        @(negedge clk);
        chk("ready_single", rdy_a, 1'b0);
        chk("ready_count", ready_pulses, 1);

        // Frame 2 wraps to row 0 with identical data
        collect_shift(rises, ones, sb_hi, ch_nz, bits, tmo);
        chk("f2_row0_bits", bits, ROW0_BITS);
        count_lat(n, bad);
        count_hold(8'h01, n);
        chk("f2_row0_hold", n, HOLD);
        for (int r = 1; r < 3; r++) begin
            collect_shift(rises, ones, sb_hi, ch_nz, bits, tmo);
            count_lat(n, bad);
            count_hold(8'(1 << r), n);
        end

        // Reset in the middle of row 3 while sck is high
        repeat (60) @(negedge clk);
        n = 0;
        while (!sck_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_shift_sck_high", {sck_a, sb_a}, 2'b11);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", {addr_a, sck_a, sda_a, lat_a, sb_a, srst_a, ch_a, rdy_a}, 20'h0);
        chk("mid_reset_state", st_a, 3'd0);
        rst_n = 1'b1;
        count_rst_low(n);
        chk("restart_rst_low", n, 16);
        collect_shift(rises, ones, sb_hi, ch_nz, bits, tmo);
        chk("restart_gamma_rises", rises, 144);
        chk("restart_gamma_sb", sb_hi, 0);

        // CLK_DIV=1 instance
        chk("div1_done", b_done, 1'b1);
        chk("div1_rises", b_rises, 192);
        chk("div1_bits", b_bits, ROW0_BITS);
        chk("div1_gap2", b_gap2, 184);
        chk("div1_gap4", b_gap4, 7);
        chk("div1_high_run", b_max_run, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/colorshield_driver.md
Name: colorshield_driver

Overview:
- Serial driver for the DM163-based 8x8 RGB colour shield.
- After reset it loads the 6-bit gamma bank, then continuously multiplexes rows 0..7. For each row it fetches 8 pixels from a frame buffer, shifts them to the DM163 (bank 1), latches them and enables the row.
- Emits a one-cycle shield_ready pulse at every frame end. Downstream samplers use it to update display-side signals only between frames.

Parameters:
- CLK_DIV, 4: clk cycles per sck half-period (sck low phase = high phase = CLK_DIV), >=1.
- HOLD_CYCLES, 1024: clk cycles a latched row stays enabled, >=1.
- RST_CYCLES, 16: clk cycles shield_rst_n is held low after reset, >=1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- pixel_addr  out  6  frame-buffer read address = {row[2:0], col[2:0]}
- pixel_data  in  24  {R[7:0], G[7:0], B[7:0]}; valid exactly 1 clk after pixel_addr is presented
- sck  out  1  DM163 serial clock
- sda  out  1  DM163 serial data
- lat  out  1  DM163 latch
- sb  out  1  DM163 bank select (0 = gamma/6-bit bank, 1 = 8-bit bank)
- shield_rst_n  out  1  DM163 reset, active low
- channel  out  8  one-hot row enable, bit r = row r
- shield_ready  out  1  one-cycle pulse at end of each full frame

Behaviour:
- Reset is synchronous: on a clk edge with rst_n=0, all outputs and state are forced regardless of the current state (mid-shift, mid-latch).
  - Reset values: sck=0, sda=0, lat=0, sb=0, shield_rst_n=0, channel=0, shield_ready=0, pixel_addr=0.
  - State = SHIELD_RST, row=0.
- All outputs are registered; no combinational path from pixel_data to any output.
- Bit timing:
  - sda is updated on the first cycle of the sck low phase.
  - sck is low for CLK_DIV cycles, then high for CLK_DIV cycles. DM163 samples on the sck rising edge.
  - sck is 0 in every state except the high phase of a shifted bit.
- States:
  - SHIELD_RST:
    - shield_rst_n=0 for RST_CYCLES cycles, then 1 (stays 1 until the next rst_n).
    - -> GAMMA.
  - GAMMA:
    - sb=0; shift 144 bits, all 1 (24 channels x 6-bit gamma = 63).
    - -> GAMMA_LATCH.
  - GAMMA_LATCH:
    - lat=1 for CLK_DIV cycles, sck=0.
    - -> FETCH with sb=1; sb stays 1 thereafter.
  - FETCH:
    - Drive pixel_addr={row,col}.
    - Next cycle, capture pixel_data into a 24-bit shift register.
    - -> SHIFT. Costs exactly 2 clk cycles per pixel, sck held 0.
  - SHIFT:
    - Shift the 24 bits MSB-first in order B[7:0], G[7:0], R[7:0].
    - Column order is 7 down to 0 (col starts at 7 each row).
    - After the pixel's 24th bit: if col=0 -> ROW_LATCH, else col-1 -> FETCH.
  - ROW_LATCH:
    - channel=0 for the whole fetch/shift/latch of a row (blanking).
    - lat=1 for CLK_DIV cycles.
    - -> ROW_ON.
  - ROW_ON:
    - channel=1<<row for HOLD_CYCLES cycles, then channel=0.
    - If row=7: row wraps to 0, shield_ready=1 for exactly one cycle (the first FETCH cycle of row 0). Otherwise row+1.
    - -> FETCH.
- Per-row data: 192 bits, 384*CLK_DIV + 16 clk cycles of shifting/fetching.
- shield_ready never asserts before the first complete frame. It never stays high two consecutive cycles.
- The frame buffer may change at any time. The driver makes no atomicity guarantee beyond per-pixel capture.

Test Plan:
- Gamma load, CLK_DIV=2, RST_CYCLES=16:
  - Release rst_n -> shield_rst_n low 16 cycles, then high.
  - Exactly 144 sck rising edges with sda=1 and sb=0 at every edge.
  - lat high 2 cycles with sck=0, then sb=1.
- Row shift, frame buffer pixel (row0,col7)=24'hFF0001, all others 0:
  - First 24 captured bits of row 0 = 0x01 (B), 0xFF... i.e. sequence 00000001 00000000 11111111.
  - Total 192 sck rises before lat.
  - channel=0 throughout, then channel=8'h01 for HOLD_CYCLES.
- Row scan/wrap, HOLD_CYCLES=8:
  - channel sequence 01,02,04,...,80,01, with 0 between rows.
  - shield_ready single-cycle pulse once per frame, immediately after the row-7 hold; first pulse only after the first full frame.
- Read latency: return pixel_data as 'hDEADBE only in the cycle after pixel_addr=6'o17 -> bits shifted for row1,col7 = BE,AD,DE (B,G,R).
- Reset mid-operation: assert rst_n=0 during SHIFT of row 3 -> next edge shows all outputs at reset values (channel=0, sck=0, lat=0). After release, the sequence restarts with SHIELD_RST and the gamma load.
- CLK_DIV=1 corner: sck toggles every clk during shift, each bit spans 2 cycles, and the row-0 output matches the CLK_DIV=2 bit sequence.
